// File: rtl/ccc_addr_update_seq_if.sv
// CCC event handshake bundle between the CCC decoder (master) and the
// address-update sequencer (slave).
interface ccc_addr_update_seq_if;
    logic       evt_valid;
    logic       evt_ready;
    logic [7:0] evt_ccc;
    logic [7:0] evt_data;
    logic       evt_virt;

    modport master (
        output evt_valid,
        output evt_ccc,
        output evt_data,
        output evt_virt,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_ccc,
        input  evt_data,
        input  evt_virt,
        output evt_ready
    );
endinterface

// File: rtl/ccc_addr_update_seq.sv
// Turns queued target-side CCC events into single-cycle CSR update strobes,
// legality-checked against current address-valid state, with a settle gap.
module ccc_addr_update_seq #(
    parameter int unsigned FifoDepth    = 4,
    parameter int unsigned SettleCycles = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    ccc_addr_update_seq_if.slave        evt_if,
    input  logic                        dyn_addr_valid_i,
    input  logic                        virt_dyn_addr_valid_i,
    input  logic                        static_addr_valid_i,
    input  logic                        virt_static_addr_valid_i,
    output logic [6:0]                  set_dasa_o,
    output logic                        set_dasa_valid_o,
    output logic                        set_dasa_virtual_device_o,
    output logic                        set_aasa_o,
    output logic                        set_aasa_virt_o,
    output logic                        rstdaa_o,
    output logic [6:0]                  newda_o,
    output logic                        set_newda_o,
    output logic                        set_newda_virtual_device_o,
    output logic [7:0]                  rst_action_o,
    output logic                        rst_action_valid_o,
    output logic                        rejected_o,
    output logic                        busy_o
);

    localparam int unsigned PtrW = $clog2(FifoDepth);
    localparam int unsigned CntW = $clog2(FifoDepth) + 1;
    localparam logic [CntW-1:0] FullCnt = CntW'(FifoDepth);
    localparam int unsigned SetW = (SettleCycles > 1) ? $clog2(SettleCycles) : 1;
    localparam logic [SetW-1:0] SettleLast = (SettleCycles == 0) ? '0 : SetW'(SettleCycles - 1);

    localparam logic [7:0] CccRstdaa   = 8'h06;
    localparam logic [7:0] CccSetaasa  = 8'h29;
    localparam logic [7:0] CccRstactB  = 8'h2A;
    localparam logic [7:0] CccSetdasa  = 8'h87;
    localparam logic [7:0] CccSetnewda = 8'h88;
    localparam logic [7:0] CccRstactD  = 8'h9A;

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StIssue  = 2'd1;
    localparam logic [1:0] StSettle = 2'd2;

    typedef struct packed {
        logic [7:0] ccc;
        logic [7:0] data;
        logic       virt;
    } evt_t;

    evt_t            mem_q [FifoDepth];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      state_q, state_d;
    logic [SetW-1:0] settle_cnt_q, settle_cnt_d;
    logic            push, pop;

    // Ready looks only at the registered count, so a same-cycle pop never frees a slot.
    assign evt_if.evt_ready = (cnt_q != FullCnt);
    assign push = evt_if.evt_valid && evt_if.evt_ready;
    assign pop  = (state_q == StIdle) && (cnt_q != '0);

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{ccc: evt_if.evt_ccc, data: evt_if.evt_data, virt: evt_if.evt_virt};
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!push && pop) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        case (state_q)
            StIdle: begin
                if (pop) state_d = StIssue;
            end
            StIssue: begin
                settle_cnt_d = '0;
                state_d      = (SettleCycles == 0) ? StIdle : StSettle;
            end
            StSettle: begin
                if (settle_cnt_q == SettleLast) begin
                    state_d = StIdle;
                end else begin
                    settle_cnt_d = settle_cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    evt_t       head;
    logic [6:0] head_addr;
    logic       addr_bad, dyn_v, static_v;

    logic [6:0] set_dasa_d, newda_d;
    logic [7:0] rst_action_d;
    logic       set_dasa_valid_d, set_dasa_virt_d, set_aasa_d, set_aasa_virt_d;
    logic       rstdaa_d, set_newda_d, set_newda_virt_d, rst_action_valid_d, rejected_d;

    assign head      = mem_q[rd_ptr_q];
    assign head_addr = head.data[7:1];
    assign addr_bad  = (head_addr == 7'h00) || (head_addr == 7'h7E);
    assign dyn_v     = head.virt ? virt_dyn_addr_valid_i : dyn_addr_valid_i;
    assign static_v  = head.virt ? virt_static_addr_valid_i : static_addr_valid_i;

    // Strobes default low so they only rise in the ISSUE cycle following a pop.
    always_comb begin
        set_dasa_d         = set_dasa_o;
        set_dasa_virt_d    = set_dasa_virtual_device_o;
        newda_d            = newda_o;
        set_newda_virt_d   = set_newda_virtual_device_o;
        rst_action_d       = rst_action_o;
        set_dasa_valid_d   = 1'b0;
        set_aasa_d         = 1'b0;
        set_aasa_virt_d    = 1'b0;
        rstdaa_d           = 1'b0;
        set_newda_d        = 1'b0;
        rst_action_valid_d = 1'b0;
        rejected_d         = 1'b0;
        if (pop) begin
            case (head.ccc)
                CccRstdaa: rstdaa_d = 1'b1;
                CccSetaasa: begin
                    if (dyn_v || !static_v) begin
                        rejected_d = 1'b1;
                    end else if (head.virt) begin
                        set_aasa_virt_d = 1'b1;
                    end else begin
                        set_aasa_d = 1'b1;
                    end
                end
                CccSetdasa: begin
                    if (dyn_v || addr_bad) begin
                        rejected_d = 1'b1;
                    end else begin
                        set_dasa_valid_d = 1'b1;
                        set_dasa_d       = head_addr;
                        set_dasa_virt_d  = head.virt;
                    end
                end
                CccSetnewda: begin
                    if (!dyn_v || addr_bad) begin
                        rejected_d = 1'b1;
                    end else begin
                        set_newda_d      = 1'b1;
                        newda_d          = head_addr;
                        set_newda_virt_d = head.virt;
                    end
                end
                CccRstactB, CccRstactD: begin
                    rst_action_valid_d = 1'b1;
                    rst_action_d       = head.data;
                end
                default: rejected_d = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q                    <= StIdle;
            settle_cnt_q               <= '0;
            set_dasa_o                 <= '0;
            set_dasa_valid_o           <= 1'b0;
            set_dasa_virtual_device_o  <= 1'b0;
            set_aasa_o                 <= 1'b0;
            set_aasa_virt_o            <= 1'b0;
            rstdaa_o                   <= 1'b0;
            newda_o                    <= '0;
            set_newda_o                <= 1'b0;
            set_newda_virtual_device_o <= 1'b0;
            rst_action_o               <= '0;
            rst_action_valid_o         <= 1'b0;
            rejected_o                 <= 1'b0;
        end else begin
            state_q                    <= state_d;
            settle_cnt_q               <= settle_cnt_d;
            set_dasa_o                 <= set_dasa_d;
            set_dasa_valid_o           <= set_dasa_valid_d;
            set_dasa_virtual_device_o  <= set_dasa_virt_d;
            set_aasa_o                 <= set_aasa_d;
            set_aasa_virt_o            <= set_aasa_virt_d;
            rstdaa_o                   <= rstdaa_d;
            newda_o                    <= newda_d;
            set_newda_o                <= set_newda_d;
            set_newda_virtual_device_o <= set_newda_virt_d;
            rst_action_o               <= rst_action_d;
            rst_action_valid_o         <= rst_action_valid_d;
            rejected_o                 <= rejected_d;
        end
    end

    assign busy_o = (cnt_q != '0) || (state_q != StIdle);

endmodule
